// File: rtl/cpu_pkg.sv
// Shared core definitions: register width and the word type used on
// data paths between the pipeline and its peripherals.
package cpu_pkg;

    localparam int WORD_W = 16;

    typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/outport_tx_sync_fifo.sv
// Synchronous FIFO: storage, read/write pointers, occupancy, full and empty.
// Callers must only push when not full and only pop when not empty.
module sync_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = WORD_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Pointers are exactly log2(DEPTH) bits wide, so they wrap on their own.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) mem[wr_ptr] <= wr_data;
    end

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    // Storage is not reset, so the head is masked to zero while nothing is held.
    assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/outport_tx.sv
// Output-port transmitter: buffers OUT-instruction words and hands them to an
// external device over valid/ready, keeping a copy of the last word delivered.
module outport_tx
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = WORD_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     ovf,
    input  logic                     ovf_clr,
    output logic                     port_valid,
    output logic [WIDTH-1:0]         port_data,
    input  logic                     port_ready,
    output logic [WIDTH-1:0]         port_hold
);

    logic push;
    logic pop;

    // full comes from registered count, so a pop never frees a slot for a
    // push in the same cycle.
    assign push       = wr_en && !full;
    assign pop        = port_valid && port_ready;
    assign port_valid = !empty;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .wr_data (wr_data),
        .rd_data (port_data),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            port_hold <= '0;
        end else if (pop) begin
            port_hold <= port_data;
        end
    end

    // A dropped write takes priority over a clear arriving in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (wr_en && full) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_outport_tx.sv
// Directed bench for outport_tx: reset, single transfer, fill/overflow/drain,
// streaming through pointer wrap, push+pop at count 2, and mid-run reset.
module tb_outport_tx;
    import cpu_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    word_t       wr_data;
    logic        full;
    logic        empty;
    logic [2:0]  count;
    logic        ovf;
    logic        ovf_clr;
    logic        port_valid;
    word_t       port_data;
    logic        port_ready;
    word_t       port_hold;

    int checks   = 0;
    int failures = 0;

    outport_tx #(
        .DEPTH (DEPTH),
        .WIDTH (WORD_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .full       (full),
        .empty      (empty),
        .count      (count),
        .ovf        (ovf),
        .ovf_clr    (ovf_clr),
        .port_valid (port_valid),
        .port_data  (port_data),
        .port_ready (port_ready),
        .port_hold  (port_hold)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Advance one rising edge; outputs are then sampled 1ns after it.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_count"}, count, 0);
        checkOutput({tag, "_empty"}, empty, 1);
        checkOutput({tag, "_full"}, full, 0);
        checkOutput({tag, "_ovf"}, ovf, 0);
        checkOutput({tag, "_valid"}, port_valid, 0);
        checkOutput({tag, "_data"}, port_data, 0);
        checkOutput({tag, "_hold"}, port_hold, 0);
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_data = '0; ovf_clr = 1'b0; port_ready = 1'b0;
        applyStimulus();
        applyStimulus();
        rst = 1'b0;
        checkReset("reset");
        for (int i = 0; i < 5; i++) begin
            applyStimulus();
            checkOutput("idle_empty", empty, 1);
            checkOutput("idle_valid", port_valid, 0);
            checkOutput("idle_hold", port_hold, 0);
            checkOutput("idle_count", count, 0);
        end

        // Single word, device not ready for 10 cycles
        wr_en = 1'b1; wr_data = 16'h1234;
        applyStimulus();
        wr_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            checkOutput("single_valid", port_valid, 1);
            checkOutput("single_data", port_data, 16'h1234);
            checkOutput("single_hold_old", port_hold, 0);
            applyStimulus();
        end
        port_ready = 1'b1;
        applyStimulus();
        port_ready = 1'b0;
        checkOutput("single_hold", port_hold, 16'h1234);
        checkOutput("single_empty", empty, 1);
        checkOutput("single_valid_low", port_valid, 0);

        // Fill to DEPTH, then overflow
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1; wr_data = 16'hA001 + 16'(i);
            applyStimulus();
            checkOutput("fill_count", count, 32'(i + 1));
            checkOutput("fill_full", full, (i == 3) ? 1 : 0);
        end
        wr_data = 16'hBEEF;
        applyStimulus();
        wr_en = 1'b0;
        checkOutput("ovf_set", ovf, 1);
        checkOutput("ovf_count", count, 4);
        checkOutput("ovf_head", port_data, 16'hA001);

        // Clear and new overflow together: set wins
        wr_en = 1'b1; ovf_clr = 1'b1;
        applyStimulus();
        wr_en = 1'b0;
        checkOutput("ovf_set_wins", ovf, 1);
        applyStimulus();
        ovf_clr = 1'b0;
        checkOutput("ovf_clr", ovf, 0);

        // Pop while full with a write pending: write still dropped
        port_ready = 1'b1; wr_en = 1'b1; wr_data = 16'hBEEF;
        applyStimulus();
        wr_en = 1'b0;
        checkOutput("fullpop_count", count, 3);
        checkOutput("fullpop_ovf", ovf, 1);
        checkOutput("fullpop_full", full, 0);
        checkOutput("fullpop_hold", port_hold, 16'hA001);
        for (int i = 1; i < 4; i++) begin
            checkOutput("drain_data", port_data, 16'hA001 + 32'(i));
            applyStimulus();
            checkOutput("drain_hold", port_hold, 16'hA001 + 32'(i));
        end
        checkOutput("drain_empty", empty, 1);
        port_ready = 1'b0; ovf_clr = 1'b1;
        applyStimulus();
        ovf_clr = 1'b0;

        // Streaming with device always ready: 20 words through 4 slots
        port_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            wr_en = 1'b1; wr_data = 16'(i);
            applyStimulus();
            checkOutput("stream_count", count, 1);
            checkOutput("stream_data", port_data, 32'(i));
            if (i > 0) checkOutput("stream_hold", port_hold, 32'(i - 1));
        end
        wr_en = 1'b0;
        applyStimulus();
        checkOutput("stream_last_hold", port_hold, 16'h0013);
        checkOutput("stream_empty", empty, 1);

        // Push and pop together at count 2
        port_ready = 1'b0;
        wr_en = 1'b1; wr_data = 16'hC001;
        applyStimulus();
        wr_data = 16'hC002;
        applyStimulus();
        checkOutput("pp_pre_count", count, 2);
        checkOutput("pp_pre_head", port_data, 16'hC001);
        wr_data = 16'hC003; port_ready = 1'b1;
        applyStimulus();
        checkOutput("pp_count", count, 2);
        checkOutput("pp_head", port_data, 16'hC002);
        checkOutput("pp_hold", port_hold, 16'hC001);

        // Reach count 3 with ovf set, then reset while writing
        port_ready = 1'b0;
        wr_data = 16'hC004;
        applyStimulus();
        wr_data = 16'hC005;
        applyStimulus();
        wr_data = 16'hC006;
        applyStimulus();
        wr_en = 1'b0; port_ready = 1'b1;
        applyStimulus();
        port_ready = 1'b0;
        checkOutput("prerst_count", count, 3);
        checkOutput("prerst_ovf", ovf, 1);
        checkOutput("prerst_head", port_data, 16'hC003);
        rst = 1'b1; wr_en = 1'b1; wr_data = 16'hDEAD; port_ready = 1'b1;
        applyStimulus();
        checkReset("midrst");
        rst = 1'b0; wr_en = 1'b0; port_ready = 1'b0;
        applyStimulus();
        checkOutput("postrst_empty", empty, 1);
        checkOutput("postrst_count", count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
